systolic_feeder: RTL and testbench

Input-staging stage that sits directly upstream of the N×N processing-element array. It captures two N×N 8-bit operand matrices on a start handshake and replays them as skewed edge streams:
- one row lane per array row, with A entering from the left;
- one column lane per array column, with B entering from the top.

It also generates the array-wide process enable. Zero padding fills the skew slots so that every PE sees exactly the N products it must accumulate.

---
 rtl/systolic_feeder.sv | 109 ++++++++++
 tb/tb_systolic_feeder.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_feeder.sv
// Operand feeder for an N x N systolic array: captures A and B on start and
// replays them as skewed, zero-padded row/column edge streams with a PE enable.

module systolic_feeder_lane #(
  parameter int N   = 4,
  parameter int W   = 8,
  parameter int TW  = 4,
  parameter int IDX = 0
) (
  input  logic [TW-1:0]       i_t,
  input  logic [N-1:0][W-1:0] i_vec,
  output logic [W-1:0]        o_val
);
  logic [TW-1:0] k;
  assign k = i_t - TW'(IDX);

  // Lane IDX is delayed by IDX steps; outside its N-step window it carries zeros.
  always_comb begin
    o_val = '0;
    if (i_t >= TW'(IDX) && k < TW'(N))
      for (int e = 0; e < N; e++)
        if (k == TW'(e)) o_val = i_vec[e];
  end
endmodule

module systolic_feeder #(
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic             i_clk,
  input  logic             i_arst,
  input  logic             i_start,
  input  logic [N*N*W-1:0] i_a,
  input  logic [N*N*W-1:0] i_b,
  output logic [N*W-1:0]   o_a,
  output logic [N*W-1:0]   o_b,
  output logic             o_doProcess,
  output logic             o_busy,
  output logic             o_done
);
  localparam int T  = 3*N-2;
  localparam int TW = $clog2(T);
  localparam logic [TW-1:0] T_LAST = TW'(T-1);

  typedef enum logic [1:0] {IDLE, FEED, DONE} state_t;
  state_t state_q, state_d;

  logic [N-1:0][N-1:0][W-1:0] a_q, b_q, b_col;
  logic [N-1:0][W-1:0]        a_lane, b_lane;
  logic [TW-1:0]              t_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (i_start) state_d = FEED;
      FEED:    if (t_q == T_LAST) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_arst) begin
      state_q <= IDLE;
      t_q     <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE)                     t_q <= '0;
      else if (state_q == FEED && t_q != T_LAST) t_q <= t_q + TW'(1);
    end
  end

  // Packing of i_a/i_b matches [r][c] packed indexing directly.
  always_ff @(posedge i_clk) begin
    if (!i_arst && state_q == IDLE && i_start) begin
      a_q <= i_a;
      b_q <= i_b;
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_lane
    for (genvar r = 0; r < N; r++) begin : g_col
      assign b_col[i][r] = b_q[r][i];
    end
    systolic_feeder_lane #(.N(N), .W(W), .TW(TW), .IDX(i)) u_row (
      .i_t(t_q), .i_vec(a_q[i]), .o_val(a_lane[i])
    );
    systolic_feeder_lane #(.N(N), .W(W), .TW(TW), .IDX(i)) u_col (
      .i_t(t_q), .i_vec(b_col[i]), .o_val(b_lane[i])
    );
  end

  // Outputs lag state by one edge so step t appears after edge k+1+t.
  always_ff @(posedge i_clk) begin
    if (i_arst) begin
      o_a         <= '0;
      o_b         <= '0;
      o_doProcess <= 1'b0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
    end else begin
      o_a         <= (state_q == FEED) ? a_lane : '0;
      o_b         <= (state_q == FEED) ? b_lane : '0;
      o_doProcess <= (state_q == FEED);
      o_busy      <= (state_q != IDLE);
      o_done      <= (state_q == DONE);
    end
  end
endmodule

// File: tb/tb_systolic_feeder.sv
// Directed bench for systolic_feeder: lane skew tables, control timing, abort,
// back-to-back passes, plus a PE-array model fed by the N=2 and N=4 instances.

module tb_systolic_feeder;
  logic        clk = 1'b0;
  logic        arst;
  logic        start2, start4;
  logic [31:0] a2, b2;
  logic [127:0] a4, b4;
  logic [15:0] o_a2, o_b2;
  logic [31:0] o_a4, o_b4;
  logic        dp2, busy2, done2, dp4, busy4, done4;

  int n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  systolic_feeder #(.N(2), .W(8)) u_dut2 (
    .i_clk(clk), .i_arst(arst), .i_start(start2), .i_a(a2), .i_b(b2),
    .o_a(o_a2), .o_b(o_b2), .o_doProcess(dp2), .o_busy(busy2), .o_done(done2)
  );
  systolic_feeder #(.N(4), .W(8)) u_dut4 (
    .i_clk(clk), .i_arst(arst), .i_start(start4), .i_a(a4), .i_b(b4),
    .o_a(o_a4), .o_b(o_b4), .o_doProcess(dp4), .o_busy(busy4), .o_done(done4)
  );

  // 4x4 output-stationary PE array model; the N=2 feeder drives its top-left corner.
  logic        sel4, mclr;
  logic [31:0] oa2x, ob2x;
  logic [7:0]  la [4], lb [4];
  logic        dp_m;
  logic [7:0]  pa [4][4], pb [4][4];
  logic [7:0]  ai [4][5], bi [5][4];
  logic [15:0] acc [4][4];

  assign oa2x = {16'h0, o_a2};
  assign ob2x = {16'h0, o_b2};
  assign dp_m = sel4 ? dp4 : dp2;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      la[i] = sel4 ? o_a4[i*8 +: 8] : oa2x[i*8 +: 8];
      lb[i] = sel4 ? o_b4[i*8 +: 8] : ob2x[i*8 +: 8];
    end
    for (int i = 0; i < 4; i++) begin
      ai[i][0] = la[i];
      bi[0][i] = lb[i];
      for (int j = 0; j < 4; j++) begin
        ai[i][j+1] = pa[i][j];
        bi[i+1][j] = pb[i][j];
      end
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        if (mclr) begin
          acc[i][j] <= 16'h0;
          pa[i][j]  <= 8'h0;
          pb[i][j]  <= 8'h0;
        end else if (dp_m) begin
          acc[i][j] <= acc[i][j] + {8'h0, ai[i][j]} * {8'h0, bi[i][j]};
          pa[i][j]  <= ai[i][j];
          pb[i][j]  <= bi[i][j];
        end
      end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] MA = 32'h04030201;  // [[1,2],[3,4]]
  localparam logic [31:0] MB = 32'h08070605;  // [[5,6],[7,8]]
  logic [15:0] ea [4] = '{16'h0001, 16'h0302, 16'h0400, 16'h0000};
  logic [15:0] eb [4] = '{16'h0005, 16'h0607, 16'h0800, 16'h0000};

  task automatic clr_model;
    mclr = 1'b1; tick; mclr = 1'b0;
  endtask

  task automatic capture2;
    a2 = MA; b2 = MB; start2 = 1'b1;
    tick;
    start2 = 1'b0;
    chk("cap_busy", busy2, 1'b0);
  endtask

  // FEED cycles plus the done cycle; ign keeps start high and scrambles inputs.
  task automatic feed2(input bit ign);
    if (ign) begin start2 = 1'b1; a2 = ~MA; b2 = 32'h11223344; end
    for (int s = 0; s < 4; s++) begin
      tick;
      chk($sformatf("row_s%0d", s), o_a2, ea[s]);
      chk($sformatf("col_s%0d", s), o_b2, eb[s]);
      chk($sformatf("ctl_s%0d", s), {dp2, busy2, done2}, 3'b110);
    end
    tick;
    chk("done_cyc", {o_a2, o_b2, dp2, busy2, done2}, {32'h0, 3'b011});
    start2 = 1'b0;
  endtask

  task automatic chk_acc2(input string tag, input logic [15:0] e00, e01, e10, e11);
    chk({tag, "00"}, acc[0][0], e00);
    chk({tag, "01"}, acc[0][1], e01);
    chk({tag, "10"}, acc[1][0], e10);
    chk({tag, "11"}, acc[1][1], e11);
  endtask

  int am [4][4], bm [4][4];
  int ndp;
  bit got_done;
  logic [15:0] e4;

  initial begin
    arst = 1'b1; start2 = 1'b0; start4 = 1'b0; a2 = '0; b2 = '0; a4 = '0; b4 = '0;
    sel4 = 1'b0; mclr = 1'b0;

    for (int c = 0; c < 3; c++) begin
      start2 = 1'($urandom_range(0, 1)); start4 = 1'($urandom_range(0, 1));
      a2 = $urandom; b2 = $urandom; a4 = {4{$urandom}}; b4 = {4{$urandom}};
      tick;
      chk("rst2", {o_a2, o_b2, dp2, busy2, done2}, 0);
      chk("rst4", {o_a4, o_b4, dp4, busy4, done4}, 0);
    end
    arst = 1'b0; start2 = 1'b0; start4 = 1'b0;
    for (int c = 0; c < 2; c++) begin
      tick;
      chk("idle2", {o_a2, o_b2, dp2, busy2, done2}, 0);
      chk("idle4", {o_a4, o_b4, dp4, busy4, done4}, 0);
    end

    // Basic pass and 2x2 array result.
    clr_model;
    capture2;
    feed2(1'b0);
    chk_acc2("p1_acc", 16'd19, 16'd22, 16'd43, 16'd50);
    tick;
    chk("p1_idle", {o_a2, o_b2, dp2, busy2, done2}, 0);

    // Start held through FEED/DONE with changed inputs: ignored.
    clr_model;
    capture2;
    feed2(1'b1);
    chk_acc2("ign_acc", 16'd19, 16'd22, 16'd43, 16'd50);
    tick;
    chk("ign_idle", {o_a2, o_b2, dp2, busy2, done2}, 0);

    // Abort during step 2.
    clr_model;
    capture2;
    tick; tick;
    arst = 1'b1;
    tick;
    chk("abort_out", {o_a2, o_b2, dp2, busy2, done2}, 0);
    arst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick;
      chk("abort_quiet", {o_a2, o_b2, dp2, busy2, done2}, 0);
    end
    clr_model;
    capture2;
    feed2(1'b0);
    chk_acc2("rec_acc", 16'd19, 16'd22, 16'd43, 16'd50);
    tick;

    // Back-to-back passes; accumulators keep summing.
    clr_model;
    capture2;
    feed2(1'b0);
    a2 = MA; b2 = MB; start2 = 1'b1;
    tick;
    start2 = 1'b0;
    chk("b2b_gap", {busy2, done2}, 2'b00);
    feed2(1'b0);
    chk_acc2("b2b_acc", 16'd38, 16'd44, 16'd86, 16'd100);
    tick;
    chk("b2b_idle", {o_a2, o_b2, dp2, busy2, done2}, 0);

    // N=4 with large operands so the 16-bit sums wrap.
    sel4 = 1'b1;
    clr_model;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        am[r][c] = (37*(r*4+c) + 200) % 256;
        bm[r][c] = (91*(r*4+c) + 150) % 256;
        a4[(r*4+c)*8 +: 8] = 8'(am[r][c]);
        b4[(r*4+c)*8 +: 8] = 8'(bm[r][c]);
      end
    start4 = 1'b1;
    tick;
    start4 = 1'b0;
    ndp = 0; got_done = 1'b0;
    for (int c = 0; c < 30 && !got_done; c++) begin
      tick;
      if (dp4) ndp++;
      if (done4) got_done = 1'b1;
    end
    chk("n4_done", got_done, 1'b1);
    chk("n4_dp_cycles", ndp, 10);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        int s;
        s = 0;
        for (int k = 0; k < 4; k++) s += am[i][k] * bm[k][j];
        e4 = 16'(s);
        chk($sformatf("n4_acc%0d%0d", i, j), acc[i][j], e4);
      end
    tick;
    chk("n4_idle", {o_a4, o_b4, dp4, busy4, done4}, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
